// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
//   Shared definitions for the instruction-fetch control slice.
//   - S_INIT / S_FETCH / S_WAIT encodings of the fetch sequencer (2 bits)
//   - fetch_state_e: enum built on those encodings
//   - RESET_PC_DEFAULT: default PC loaded while the sequencer is initialising
// ----------------------------------------------------------------------------
package if_pkg;

  localparam logic [1:0] S_INIT_ENC  = 2'd0;
  localparam logic [1:0] S_FETCH_ENC = 2'd1;
  localparam logic [1:0] S_WAIT_ENC  = 2'd2;

  typedef enum logic [1:0] {
    S_INIT  = S_INIT_ENC,
    S_FETCH = S_FETCH_ENC,
    S_WAIT  = S_WAIT_ENC
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/redirect_buffer.sv
// ----------------------------------------------------------------------------
// redirect_buffer
//   Holds one branch/jump redirect that arrived while a fetch was still
//   outstanding, so it can be applied when that fetch completes.
//   Ports:
//     CLK         in   1      clock
//     Reset       in   1      synchronous, active-high reset
//     set         in   1      capture d and raise pend
//     clr         in   1      drop the buffered redirect (wins over set)
//     d           in   WIDTH  redirect target to capture
//     pend        out  1      a redirect is buffered
//     pend_target out  WIDTH  buffered redirect target
// ----------------------------------------------------------------------------
module redirect_buffer
  import if_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             set,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic             pend,
  output logic [WIDTH-1:0] pend_target
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      // NOTE: the target register is reset too, so a stale address can never
      // be observed even though pend already qualifies it.
      pend        <= 1'b0;
      pend_target <= '0;
    end else if (clr) begin
      pend        <= 1'b0;
    end else if (set) begin
      pend        <= 1'b1;
      pend_target <= d;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Sequences the IF stage against a variable-latency instruction memory:
//   decides each cycle whether the PC advances, holds or is redirected,
//   buffers a redirect that arrives mid-fetch, and drives IF/ID hold/flush.
//   Ports:
//     CLK              in   1      clock
//     Reset            in   1      synchronous, active-high reset
//     Imem_Ready       in   1      instruction memory completes the fetch
//     Hazard_Stall     in   1      load-use stall request from ID
//     Branch           in   1      EX holds a conditional branch
//     Zero             in   1      ALU zero flag for that branch
//     Jump             in   1      EX holds an unconditional jump
//     Target           in   WIDTH  branch/jump target
//     nextPc           in   WIDTH  PC+4 from the IF adder
//     PC_i             out  WIDTH  value loaded by the PC register
//     PC_Hold          out  1      PC register keeps its value
//     Imem_Req         out  1      fetch request
//     IF_ID_Hold       out  1      IF/ID keeps its value
//     IF_ID_Flush      out  1      IF/ID loads a bubble (wins over hold)
//     Redirect_Pending out  1      a buffered redirect is waiting
// ----------------------------------------------------------------------------
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int               WIDTH             = 32,
  parameter logic [WIDTH-1:0] RESET_PC          = WIDTH'(RESET_PC_DEFAULT),
  parameter int               RESET_HOLD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Imem_Ready,
  input  logic             Hazard_Stall,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             Jump,
  input  logic [WIDTH-1:0] Target,
  input  logic [WIDTH-1:0] nextPc,
  output logic [WIDTH-1:0] PC_i,
  output logic             PC_Hold,
  output logic             Imem_Req,
  output logic             IF_ID_Hold,
  output logic             IF_ID_Flush,
  output logic             Redirect_Pending
);

  localparam int CNT_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  fetch_state_e     state;
  logic [CNT_W-1:0] hold_cnt;

  logic             take;
  logic             done;
  logic             pend;
  logic [WIDTH-1:0] pend_target;
  logic             buf_set;
  logic             buf_clr;

  assign take = Jump | (Branch & Zero);
  assign done = Imem_Req & Imem_Ready;

  assign Redirect_Pending = pend;

  redirect_buffer #(.WIDTH(WIDTH)) u_redirect_buffer (
    .CLK         (CLK),
    .Reset       (Reset),
    .set         (buf_set),
    .clr         (buf_clr),
    .d           (Target),
    .pend        (pend),
    .pend_target (pend_target)
  );

  // Sequencer: S_INIT for RESET_HOLD_CYCLES cycles, then S_FETCH/S_WAIT
  // tracking whether the outstanding fetch completed this cycle.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_INIT;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (hold_cnt == CNT_LAST) begin
            state <= S_FETCH;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_FETCH, S_WAIT: state <= Imem_Ready ? S_FETCH : S_WAIT;
        default:         state <= S_INIT;
      endcase
    end
  end

  // Output mux. Priority inside a fetch: redirect > stall > memory wait.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    PC_i        = nextPc;
    PC_Hold     = 1'b1;
    Imem_Req    = 1'b0;
    IF_ID_Hold  = 1'b0;
    IF_ID_Flush = 1'b0;
    buf_set     = 1'b0;
    buf_clr     = 1'b0;

    if (state == S_FETCH || state == S_WAIT) begin
      Imem_Req = 1'b1;
      if (Imem_Ready) begin
        if (pend || take) begin
          // Returning instruction is wrong-path: drop it and steer the PC.
          // The buffered (older) redirect outranks a fresh one.
          PC_Hold     = 1'b0;
          PC_i        = pend ? pend_target : Target;
          IF_ID_Flush = 1'b1;
          buf_clr     = 1'b1;
        end else if (Hazard_Stall) begin
          // Keep the PC so the returned instruction is fetched again.
          IF_ID_Hold = 1'b1;
        end else begin
          PC_Hold = 1'b0;
        end
      end else begin
        // Only the first redirect seen while waiting is kept.
        buf_set = take & ~pend;
        if (take || pend) begin
          IF_ID_Flush = 1'b1;
        end else if (Hazard_Stall) begin
          IF_ID_Hold = 1'b1;
        end else begin
          IF_ID_Flush = 1'b1;
        end
      end
    end else begin
      // S_INIT (and any illegal encoding): load RESET_PC, keep IF/ID empty.
      PC_Hold     = 1'b0;
      PC_i        = RESET_PC;
      IF_ID_Flush = 1'b1;
    end
  end

endmodule
